// File: rtl/seq_gen_if.sv
// Load handshake and serial output bundle for seq_gen.
// The master side supplies pattern/count/gap; the slave side is the generator.
interface seq_gen_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
);
  logic [PAT_W-1:0] pat_in;
  logic [CNT_W-1:0] rep_in;
  logic [GAP_W-1:0] gap_in;
  logic             load_valid;
  logic             load_ready;
  logic             abort;
  logic             seq_out;
  logic             seq_valid;
  logic             last_bit;
  logic             busy;

  modport master (
    output pat_in, rep_in, gap_in, load_valid, abort,
    input  load_ready, seq_out, seq_valid, last_bit, busy
  );

  modport slave (
    input  pat_in, rep_in, gap_in, load_valid, abort,
    output load_ready, seq_out, seq_valid, last_bit, busy
  );
endinterface

// File: rtl/seq_gen.sv
// Serial bit-sequence generator: shifts a loaded pattern out MSB-first,
// repeated rep times with an optional idle gap between repetitions.
//
// state   | meaning
// S_IDLE  | waiting for a load, line at IDLE_BIT
// S_SHIFT | driving pat_reg[idx] on seq_out
// S_GAP   | idle cycles between repetitions
module seq_gen #(
  parameter int   PAT_W    = 4,
  parameter int   CNT_W    = 8,
  parameter int   GAP_W    = 4,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic      clk,
  input  logic      reset_n,
  seq_gen_if.slave  bus
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    idx_d   = idx_q;
    if (bus.abort) begin
      // abort wins over everything, including a load in IDLE
      state_d = S_IDLE;
      rep_d   = '0;
      gcnt_d  = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.load_valid) begin
            pat_d   = bus.pat_in;
            rep_d   = (bus.rep_in == '0) ? CNT_W'(1) : bus.rep_in;
            gap_d   = bus.gap_in;
            idx_d   = IDX_MAX;
            state_d = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (idx_q != '0) begin
            idx_d = idx_q - IDX_W'(1);
          end else if (rep_q == CNT_W'(1)) begin
            state_d = S_IDLE;
            rep_d   = '0;
          end else begin
            rep_d = rep_q - CNT_W'(1);
            idx_d = IDX_MAX;
            if (gap_q != '0) begin
              state_d = S_GAP;
              gcnt_d  = gap_q;
            end
          end
        end
        S_GAP: begin
          gcnt_d = gcnt_q - GAP_W'(1);
          if (gcnt_q == GAP_W'(1)) begin
            state_d = S_SHIFT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decode registered state only, so no input reaches an output
  always_comb begin
    bus.load_ready = 1'b0;
    bus.seq_valid  = 1'b0;
    bus.seq_out    = IDLE_BIT;
    bus.last_bit   = 1'b0;
    bus.busy       = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        bus.load_ready = 1'b1;
        bus.busy       = 1'b0;
      end
      S_SHIFT: begin
        bus.seq_valid = 1'b1;
        bus.seq_out   = pat_q[idx_q];
        bus.last_bit  = (idx_q == '0) && (rep_q == CNT_W'(1));
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: directed scenarios plus randomized
// transfers compared against a per-cycle expected stream built from the rules.
module tb_seq_gen;
  localparam int   PAT_W    = 4;
  localparam int   CNT_W    = 8;
  localparam int   GAP_W    = 4;
  localparam logic IDLE_BIT = 1'b0;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  // expected per-cycle {busy, seq_valid, seq_out, last_bit}
  logic [3:0] exp_q[$];

  seq_gen_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

  seq_gen #(
    .PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W), .IDLE_BIT(IDLE_BIT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] obs();
    return {bus.busy, bus.seq_valid, bus.seq_out, bus.last_bit};
  endfunction

  task automatic build_exp(input logic [PAT_W-1:0] p, input int r, input int g);
    int reps;
    reps = (r == 0) ? 1 : r;
    exp_q.delete();
    for (int k = 0; k < reps; k++) begin
      for (int b = PAT_W - 1; b >= 0; b--)
        exp_q.push_back({1'b1, 1'b1, p[b], (k == reps - 1) && (b == 0)});
      if (k < reps - 1)
        for (int j = 0; j < g; j++) exp_q.push_back({1'b1, 1'b0, IDLE_BIT, 1'b0});
    end
  endtask

  // Ends at the falling edge of the first cycle after the accepting edge
  task automatic start_load(input logic [PAT_W-1:0] p, input int r, input int g);
    @(negedge clk);
    bus.pat_in = p;
    bus.rep_in = CNT_W'(r);
    bus.gap_in = GAP_W'(g);
    bus.load_valid = 1'b1;
    build_exp(p, r, g);
    @(negedge clk);
    bus.load_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({obs(), bus.load_ready} !== {1'b0, 1'b0, IDLE_BIT, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_outputs: got %b/%b expected 0000/1", obs(), bus.load_ready);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    start_load(4'b1011, 1, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs() !== exp_q[i]) begin
        errors++;
        $display("FAIL single bit%0d: got %b expected %b", i, obs(), exp_q[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (bus.load_ready !== 1'b1 || bus.seq_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_ready: got ready=%b valid=%b expected 1/0", bus.load_ready, bus.seq_valid);
    end
  endtask

  task automatic test_rep_gap();
    int lasts = 0, valids = 0;
    start_load(4'b1011, 3, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs() !== exp_q[i]) begin
        errors++;
        $display("FAIL rep_gap cyc%0d: got %b expected %b", i, obs(), exp_q[i]);
      end
      lasts  += int'(bus.last_bit);
      valids += int'(bus.seq_valid);
      @(negedge clk);
    end
    checks++;
    if (lasts != 1 || valids != 12 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rep_gap_counts: got last=%0d valid=%0d busy=%b expected 1/12/0", lasts, valids, bus.busy);
    end
  endtask

  task automatic test_zero_b2b();
    start_load(4'b1101, 0, 3);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs() !== exp_q[i]) begin
        errors++;
        $display("FAIL rep_zero cyc%0d: got %b expected %b", i, obs(), exp_q[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rep_zero_end: got busy=%b expected 0", bus.busy);
    end
    start_load(4'b0110, 2, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs() !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b cyc%0d: got %b expected %b", i, obs(), exp_q[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    int lasts = 0;
    start_load(4'b1011, 5, 0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (obs() !== 4'b1110) begin
      errors++;
      $display("FAIL abort_third_bit: got %b expected 1110", obs());
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if ({obs(), bus.load_ready} !== {1'b0, 1'b0, IDLE_BIT, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL abort_idle: got %b/%b expected 0000/1", obs(), bus.load_ready);
    end
    repeat (8) begin
      lasts += int'(bus.last_bit) + int'(bus.seq_valid);
      @(negedge clk);
    end
    checks++;
    if (lasts != 0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d active cycles expected 0", lasts);
    end
    bus.pat_in = 4'b1111;
    bus.rep_in = 8'd2;
    bus.load_valid = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.load_valid = 1'b0;
    bus.abort = 1'b0;
    lasts = 0;
    repeat (3) begin
      lasts += int'(bus.busy) + int'(bus.seq_valid);
      @(negedge clk);
    end
    checks++;
    if (lasts != 0) begin
      errors++;
      $display("FAIL abort_blocks_load: got %0d active cycles expected 0", lasts);
    end
  endtask

  task automatic test_reset_mid();
    start_load(4'b1011, 3, 5);
    repeat (5) @(negedge clk);
    checks++;
    if (obs() !== {1'b1, 1'b0, IDLE_BIT, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_in_gap: got %b expected 1000", obs());
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({obs(), bus.load_ready} !== {1'b0, 1'b0, IDLE_BIT, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_async: got %b/%b expected 0000/1", obs(), bus.load_ready);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    start_load(4'b1011, 1, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs() !== exp_q[i]) begin
        errors++;
        $display("FAIL reset_mid_reload bit%0d: got %b expected %b", i, obs(), exp_q[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stability();
    logic [PAT_W-1:0] p;
    int r, g;
    p = PAT_W'($urandom);
    r = int'($urandom_range(2, 4));
    g = int'($urandom_range(1, 3));
    @(negedge clk);
    bus.pat_in = p;
    bus.rep_in = CNT_W'(r);
    bus.gap_in = GAP_W'(g);
    bus.load_valid = 1'b1;
    build_exp(p, r, g);
    @(negedge clk);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs() !== exp_q[i] || bus.load_ready !== 1'b0) begin
        errors++;
        $display("FAIL stability cyc%0d: got %b ready=%b expected %b ready=0", i, obs(), bus.load_ready, exp_q[i]);
      end
      bus.pat_in = PAT_W'($urandom);
      bus.rep_in = CNT_W'($urandom);
      bus.gap_in = GAP_W'($urandom);
      @(negedge clk);
    end
    checks++;
    if (bus.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL stability_ready: got %b expected 1", bus.load_ready);
    end
    bus.load_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_boundaries();
    start_load(4'b1001, 255, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs() !== exp_q[i]) begin
        errors++;
        $display("FAIL rep_max cyc%0d: got %b expected %b", i, obs(), exp_q[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rep_max_end: got busy=%b expected 0", bus.busy);
    end
    start_load(4'b0111, 2, 15);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs() !== exp_q[i]) begin
        errors++;
        $display("FAIL gap_max cyc%0d: got %b expected %b", i, obs(), exp_q[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [PAT_W-1:0] p;
    int r, g;
    for (int t = 0; t < 25; t++) begin
      p = PAT_W'($urandom);
      r = int'($urandom_range(0, 6));
      g = int'($urandom_range(0, 4));
      start_load(p, r, g);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs() !== exp_q[i]) begin
          errors++;
          $display("FAIL random t%0d cyc%0d: got %b expected %b", t, i, obs(), exp_q[i]);
        end
        @(negedge clk);
      end
      checks++;
      if (bus.load_ready !== 1'b1 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL random_end t%0d: got ready=%b busy=%b expected 1/0", t, bus.load_ready, bus.busy);
      end
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end
  endtask

  initial begin
    bus.pat_in = '0;
    bus.rep_in = '0;
    bus.gap_in = '0;
    bus.load_valid = 1'b0;
    bus.abort = 1'b0;
    test_reset();
    test_single();
    test_rep_gap();
    test_zero_b2b();
    test_abort();
    test_reset_mid();
    test_stability();
    test_boundaries();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_gen.md
# seq_gen

Serial bit-sequence generator: accepts a PAT_W-bit pattern, a repetition count and an inter-repetition gap through a valid/ready load handshake. It shifts the pattern out MSB-first, one bit per clock, on a single serial line. It is the transmit-side counterpart of the serial sequence detectors in this design, and drives their serial input in system use and in self-checking benches.

## Interface
- PAT_W, 4: pattern width in bits (≥2).
- CNT_W, 8: repetition-count width.
- GAP_W, 4: inter-repetition gap-count width.
- IDLE_BIT, 1'b0: line level driven whenever no pattern bit is being sent.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pat_in  in  PAT_W  pattern to send; bit PAT_W-1 goes out first.
- rep_in  in  CNT_W  number of repetitions; 0 is treated as 1.
- gap_in  in  GAP_W  idle cycles inserted between repetitions; 0 means back-to-back.
- load_valid  in  1  load request.
- load_ready  out  1  generator can accept a load.
- abort  in  1  synchronous cancel of the current transfer.
- seq_out  out  1  serial data line.
- seq_valid  out  1  seq_out carries a pattern bit this cycle.
- last_bit  out  1  this cycle carries the final bit of the final repetition.
- busy  out  1  state is not IDLE.

## Operation
- Three states:
  - IDLE: load_ready=1, seq_valid=0, seq_out=IDLE_BIT, busy=0.
  - SHIFT: load_ready=0, seq_valid=1, seq_out=pat_reg[idx], busy=1.
  - GAP: load_ready=0, seq_valid=0, seq_out=IDLE_BIT, busy=1.
- All outputs are registered Moore outputs of the state and its registers. No input-to-output combinational path exists, including load_ready.
- Load is accepted when load_valid && load_ready && !abort. On that edge:
  - pat_reg←pat_in
  - rep_left←(rep_in==0 ? 1 : rep_in)
  - gap_reg←gap_in
  - idx←PAT_W-1
  - state←SHIFT
- SHIFT, idx>0: idx←idx-1.
- SHIFT, idx==0, rep_left==1: state←IDLE.
- SHIFT, idx==0, rep_left>1: rep_left←rep_left-1 and idx←PAT_W-1. Then:
  - gap_reg==0: stay in SHIFT.
  - gap_reg>0: go to GAP with gap_cnt←gap_reg.
- GAP: gap_cnt decrements each cycle. In the cycle gap_cnt==1, state←SHIFT.
- last_bit=1 only in SHIFT with idx==0 and rep_left==1; otherwise 0.
- abort=1 in any state: state←IDLE on the next edge, and all counters clear. An abort in IDLE is a no-op and blocks a same-cycle load.
- Inputs pat_in, rep_in and gap_in are sampled only on the accepting edge. Changes during a transfer have no effect.

## Timing
- Reset (reset_n low, asynchronous) puts the block in IDLE:
  - seq_out=IDLE_BIT, seq_valid=0, last_bit=0, busy=0, load_ready=1.
  - pat_reg, rep_left, gap_cnt and idx all clear to 0.
- Reset released mid-transfer: the transfer is lost and is not resumed.
- Latency: if the load is accepted at edge E, the first bit (pat_in[PAT_W-1]) is on seq_out in the cycle after E.
- One repetition occupies exactly PAT_W consecutive seq_valid cycles.
- Total transfer length is rep×PAT_W + (rep-1)×gap cycles. Only the final bit asserts last_bit.
- After last_bit the block is in IDLE (load_ready=1) for at least one cycle. Two separate loads are therefore always separated by at least one seq_valid=0 cycle; use rep_in for gapless streams.
- rep_in at maximum (2^CNT_W-1): the count is exact, with no wrap.
- gap_in at maximum (2^GAP_W-1): exactly that many idle cycles.
- abort asserted in the same cycle as last_bit: the result is IDLE, identical to normal completion.

## Test plan
- Single pattern: pat_in=4'b1011, rep_in=1, gap_in=0.
  - seq_out=1,0,1,1 in the 4 cycles after the load edge, with seq_valid=1 throughout.
  - last_bit only on the 4th bit.
  - load_ready=1 in the 5th cycle.
- Repetition with gap: pat=1011, rep=3, gap=2.
  - seq_out runs 1011 __ 1011 __ 1011 (each "_" is IDLE_BIT with seq_valid=0), 16 cycles total.
  - Exactly one last_bit pulse.
- Zero and back-to-back: rep_in=0 sends exactly one repetition. pat=0110, rep=2, gap=0 sends 01100110 with no idle cycle.
- Abort: load pat=1011, rep=5, then raise abort on the 3rd bit.
  - Next cycle: seq_valid=0, seq_out=IDLE_BIT, busy=0, load_ready=1.
  - No last_bit is seen.
  - In a separate case, load_valid and abort in the same IDLE cycle: no transfer starts.
- Reset mid-operation: drop reset_n asynchronously (between clock edges) during GAP.
  - All outputs reach their reset values immediately, without waiting for a clock edge.
  - After release, a fresh load of 1011 sends correctly.
- Input stability: change pat_in, rep_in and gap_in every cycle during a transfer. The output matches the values captured at the accepting edge, and load_valid held high is ignored until IDLE.
